alu_seq_core: RTL and testbench

Parametrised, registered successor to the combinational processor ALU. Accepts one operation per valid/ready handshake and executes logic, add and shift ops in one cycle. Multiply (and optionally divide) runs as an iterative multi-cycle shift-add. Result and a 4-bit flag register are held until the processor accepts them; flags are updated only by ALU-class opcodes.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_seq_core_if.sv | 34 +++
 rtl/alu_seq_muldiv.sv | 119 +++++++++++
 rtl/alu_seq_core.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the sequential ALU core:
//   - select nibble value that marks an ALU-class opcode (ALU_SEL)
//   - operation-nibble codes OP_ADD .. OP_DIV
//   - bit positions inside the 4-bit flag word {V,N,C,Z}
//   - FSM state type and state encodings (exported on dbg_state)
//   - pack_flags helper that places V/N/C/Z at their fixed bit positions
// Optional feature macro: ALU_DIV_EN (consumed by alu_seq_core/alu_seq_muldiv).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_SEL = 4'h1;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_MUL = 4'h8;
   localparam logic [3:0] OP_DIV = 4'h9;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   // Flag word after reset: result register holds zero, so only Z is set.
   localparam logic [3:0] FLAGS_RESET = 4'b0001;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DIV  = 2'd2;

   function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                             input logic c, input logic z);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_V] = v;
      f[FLAG_N] = n;
      f[FLAG_C] = c;
      f[FLAG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_seq_core_if.sv
// -----------------------------------------------------------------------------
// alu_seq_core_if
// Bundles the request/response signals between a processor and alu_seq_core.
//   in_valid/in_ready  : request handshake, opcode/a/b qualified by in_valid
//   out_valid/out_ready: response handshake, c/flags qualified by out_valid
//   busy               : core is iterating a multiply/divide
//   dbg_state          : current FSM state (alu_pkg ST_* encoding)
// Modports: master = processor side, slave = ALU core side.
// -----------------------------------------------------------------------------
interface alu_seq_core_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [15:0]           opcode;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] c;
   logic [3:0]            flags;
   logic                  busy;
   logic [1:0]            dbg_state;

   modport master (
      output in_valid, opcode, a, b, out_ready,
      input  in_ready, out_valid, c, flags, busy, dbg_state
   );

   modport slave (
      input  in_valid, opcode, a, b, out_ready,
      output in_ready, out_valid, c, flags, busy, dbg_state
   );
endinterface

// File: rtl/alu_seq_muldiv.sv
// -----------------------------------------------------------------------------
// alu_seq_muldiv
// Iterative unsigned shift-add multiplier and, when ALU_DIV_EN is defined,
// unsigned restoring divider. One bit per clock, DATA_WIDTH iterations.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (abandons any operation)
//   start       : load operands a/b and begin iterating
//   is_div      : (ALU_DIV_EN only) select divide instead of multiply at start
//   a, b        : operands (multiplicand/multiplier or dividend/divisor)
//   div_zero    : (ALU_DIV_EN only) captured divisor is zero
//   done        : combinational, high during the last iteration cycle
//   result      : value valid while done (low product half or quotient)
//   hi_nz       : while done, upper product half is non-zero
// Optional feature macro: ALU_DIV_EN.
// -----------------------------------------------------------------------------
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
`ifdef ALU_DIV_EN
   input  logic                  is_div,
   output logic                  div_zero,
`endif
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  hi_nz
);

   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   // acc holds {upper product, remaining multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   logic [2*DW-1:0] acc;
   logic [2*DW-1:0] acc_nxt;
   logic [DW-1:0]   opnd;
   logic [CW-1:0]   cnt;
   logic            run;

   logic [DW:0]     mul_sum;
   logic [2*DW-1:0] mul_nxt;

`ifdef ALU_DIV_EN
   logic            div_mode;
   logic [DW:0]     div_shift;
   logic [DW:0]     div_diff;
   logic [2*DW-1:0] div_nxt;
`endif

   // Multiply step: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right.
   always_comb begin
      mul_sum = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : {(DW+1){1'b0}});
      mul_nxt = {mul_sum, acc[DW-1:1]};
   end

`ifdef ALU_DIV_EN
   // Restoring divide step: shift next dividend bit into the remainder and
   // subtract the divisor when it fits. A compare is used (not the borrow of
   // the subtraction) so a zero divisor yields all-ones quotient bits even
   // when the shifted remainder reaches bit DW.
   always_comb begin
      div_shift = acc[2*DW-1:DW-1];
      div_diff  = div_shift - {1'b0, opnd};
      if (div_shift >= {1'b0, opnd}) begin
         div_nxt = {div_diff[DW-1:0], acc[DW-2:0], 1'b1};
      end else begin
         div_nxt = {div_shift[DW-1:0], acc[DW-2:0], 1'b0};
      end
   end

   assign acc_nxt  = div_mode ? div_nxt : mul_nxt;
   assign div_zero = (opnd == '0);
`else
   assign acc_nxt  = mul_nxt;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= '0;
         opnd <= '0;
         cnt  <= '0;
         run  <= 1'b0;
`ifdef ALU_DIV_EN
         div_mode <= 1'b0;
`endif
      end else if (start) begin
         run <= 1'b1;
         cnt <= '0;
`ifdef ALU_DIV_EN
         div_mode <= is_div;
         opnd     <= is_div ? b : a;
         acc      <= is_div ? {{DW{1'b0}}, a} : {{DW{1'b0}}, b};
`else
         opnd <= a;
         acc  <= {{DW{1'b0}}, b};
`endif
      end else if (run) begin
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         if (cnt == CW'(DW - 1)) begin
            run <= 1'b0;
         end
      end
   end

   // The final iteration's value is handed out combinationally so the core
   // can register it on the same edge that retires the operation.
   assign done   = run && (cnt == CW'(DW - 1));
   assign result = acc_nxt[DW-1:0];
   assign hi_nz  = |acc_nxt[2*DW-1:DW];

endmodule

// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core
// Registered ALU with valid/ready request and response handshakes.
// Single-cycle: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, undefined ops.
// Multi-cycle : MUL (and DIV with ALU_DIV_EN) through alu_seq_muldiv.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : alu_seq_core_if.slave (in_valid/in_ready/opcode/a/b,
//           out_valid/out_ready/c/flags, busy, dbg_state)
// opcode[15:12] selects the class (ALU_SEL = ALU op), opcode[11:8] the
// operation, opcode[7:0] is ignored. Non-ALU selects return c=0 and leave
// flags untouched.
// Optional feature macro: ALU_DIV_EN (operation 9 = unsigned divide).
//
// Handshake rules: a request transfers on a clock edge where in_valid and
// in_ready are both high; a response transfers on an edge where out_valid and
// out_ready are both high. c/flags stay constant while out_valid is high and
// out_ready is low. in_ready is only high in IDLE when the output register is
// empty or being drained in the same cycle.
// -----------------------------------------------------------------------------
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input logic            clk,
   input logic            reset,
   alu_seq_core_if.slave  bus
);

   localparam int DW = DATA_WIDTH;

   state_t           state;
   logic [DW-1:0]    c_q;
   logic [3:0]       flags_q;
   logic             out_valid_q;

   logic [3:0]       sel;
   logic [3:0]       op;
   logic [7:0]       unused_opcode_lo;
   logic             is_alu;
   logic             is_mul;
   logic             in_ready;
   logic             accept;
   logic             start_md;

   logic [SHAMT_WIDTH-1:0] shamt;
   logic [DW:0]      sum_ext;
   logic [DW:0]      sh_ext;
   logic [DW-1:0]    alu_res;
   logic             alu_cf;
   logic             alu_vf;
   logic [3:0]       alu_flags;

   logic             md_done;
   logic [DW-1:0]    md_result;
   logic             md_hi_nz;
   logic [3:0]       md_flags;

   assign sel              = bus.opcode[15:12];
   assign op               = bus.opcode[11:8];
   assign unused_opcode_lo = bus.opcode[7:0];
   assign shamt            = bus.b[SHAMT_WIDTH-1:0];

   assign is_alu   = (sel == ALU_SEL);
   assign is_mul   = is_alu && (op == OP_MUL);
   assign in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

`ifdef ALU_DIV_EN
   logic is_div;
   logic md_div_zero;
   assign is_div   = is_alu && (op == OP_DIV);
   assign start_md = accept && (is_mul || is_div);
`else
   assign start_md = accept && is_mul;
`endif

   // Single-cycle datapath, evaluated on the live operands at accept time.
   always_comb begin
      alu_res = '0;
      alu_cf  = 1'b0;
      alu_vf  = 1'b0;
      sum_ext = '0;
      sh_ext  = '0;
      case (op)
         OP_ADD: begin
            sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
            alu_res = sum_ext[DW-1:0];
            alu_cf  = sum_ext[DW];
            alu_vf  = (bus.a[DW-1] == bus.b[DW-1]) && (alu_res[DW-1] != bus.a[DW-1]);
         end
         OP_SUB: begin
            sum_ext = {1'b0, bus.a} - {1'b0, bus.b};
            alu_res = sum_ext[DW-1:0];
            alu_cf  = sum_ext[DW];  // borrow, i.e. a < b unsigned
            alu_vf  = (bus.a[DW-1] != bus.b[DW-1]) && (alu_res[DW-1] != bus.a[DW-1]);
         end
         OP_AND: alu_res = bus.a & bus.b;
         OP_OR:  alu_res = bus.a | bus.b;
         OP_XOR: alu_res = bus.a ^ bus.b;
         OP_NOT: alu_res = ~bus.a;
         OP_SHL: begin
            // Extra MSB catches the last bit shifted out; stays 0 for amount 0.
            sh_ext  = {1'b0, bus.a} << shamt;
            alu_res = sh_ext[DW-1:0];
            alu_cf  = sh_ext[DW];
         end
         OP_SHR: begin
            // Extra LSB catches the last bit shifted out; stays 0 for amount 0.
            sh_ext  = {bus.a, 1'b0} >> shamt;
            alu_res = sh_ext[DW:1];
            alu_cf  = sh_ext[0];
         end
         default: alu_res = '0;
      endcase
   end

   assign alu_flags = pack_flags(alu_vf, alu_res[DW-1], alu_cf, alu_res == '0);

   alu_seq_muldiv #(
      .DATA_WIDTH (DW)
   ) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start    (start_md),
`ifdef ALU_DIV_EN
      .is_div   (is_div),
      .div_zero (md_div_zero),
`endif
      .a        (bus.a),
      .b        (bus.b),
      .done     (md_done),
      .result   (md_result),
      .hi_nz    (md_hi_nz)
   );

   always_comb begin
      md_flags = pack_flags(1'b0, md_result[DW-1], md_hi_nz, md_result == '0);
`ifdef ALU_DIV_EN
      if (state == ST_DIV) begin
         if (md_div_zero) begin
            md_flags = pack_flags(1'b1, 1'b1, 1'b1, 1'b0);
         end else begin
            md_flags = pack_flags(1'b0, md_result[DW-1], 1'b0, md_result == '0);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         c_q         <= '0;
         flags_q     <= FLAGS_RESET;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_md) begin
`ifdef ALU_DIV_EN
                  state <= is_mul ? ST_MUL : ST_DIV;
`else
                  state <= ST_MUL;
`endif
               end
            end
            ST_MUL: begin
               if (md_done) state <= ST_IDLE;
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
               if (md_done) state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase

         // An accepted request implies any held result is drained this cycle,
         // so loading a new single-cycle result keeps out_valid high.
         if (md_done) begin
            c_q         <= md_result;
            flags_q     <= md_flags;
            out_valid_q <= 1'b1;
         end else if (accept && !start_md) begin
            out_valid_q <= 1'b1;
            if (is_alu) begin
               c_q     <= alu_res;
               flags_q <= alu_flags;
            end else begin
               c_q     <= '0;
            end
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.c         = c_q;
   assign bus.flags     = flags_q;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_seq_core.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_core
// Directed bench for alu_seq_core (DATA_WIDTH=16). Requests are issued by a
// driver task that pushes the hand-computed {c,flags} into exp_q when the
// request is accepted; an independent monitor pops and compares on every
// response handshake. Timing, backpressure and reset behaviour are checked
// inline. Honors ALU_DIV_EN for the operation-9 expectations.
// -----------------------------------------------------------------------------
module tb_alu_seq_core;

   localparam int W = 16;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   res_idx = 0;

   logic [W+3:0] exp_q[$];
   logic [W+3:0] mon_exp;

   alu_seq_core_if #(.DATA_WIDTH(W)) bus();

   alu_seq_core #(.DATA_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got c=0x%0h flags=%b with nothing expected",
                     bus.c, bus.flags);
         end else begin
            mon_exp = exp_q.pop_front();
            check($sformatf("result%0d_c", res_idx), 32'(bus.c), 32'(mon_exp[W+3:4]));
            check($sformatf("result%0d_flags", res_idx), 32'(bus.flags), 32'(mon_exp[3:0]));
            res_idx++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [15:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic push, input logic [W-1:0] ec, input logic [3:0] ef);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.a        = aa;
      bus.b        = bb;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok && push) exp_q.push_back({ec, ef});
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: opcode 0x%h not accepted, in_ready=%b", op, bus.in_ready);
      end
      @(posedge clk);
      #1;
      // Scramble the request lines so captured operands are exercised.
      bus.in_valid = 1'b0;
      bus.opcode   = 16'($urandom);
      bus.a        = W'($urandom_range(0, 65535));
      bus.b        = W'($urandom_range(0, 65535));
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !bus.out_valid && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int start_cyc;
      int n;
      int busy_cnt;
      bit stable;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.opcode    = 16'h0000;
      bus.a         = '0;
      bus.b         = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("reset_c", 32'(bus.c), 32'h0);
      check("reset_flags", 32'(bus.flags), 32'b0001);
      check("reset_out_valid", 32'(bus.out_valid), 32'h0);
      check("reset_in_ready", 32'(bus.in_ready), 32'h1);
      check("reset_busy", 32'(bus.busy), 32'h0);
      check("reset_state", 32'(bus.dbg_state), 32'h0);

      // Streaming single-cycle ops, one per clock.
      start_cyc = cyc;
      issue(16'h1000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0011);
      check("add_latency", 32'(bus.out_valid), 32'h1);
      issue(16'h1000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1100);
      issue(16'h1100, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b0110);
      issue(16'h1600, 16'h8001, 16'h0004, 1'b1, 16'h0010, 4'b0000);
      issue(16'h1700, 16'h0003, 16'h0001, 1'b1, 16'h0001, 4'b0010);
      check("stream_cycles", 32'(cyc - start_cyc), 32'd5);
      wait_drain();

      // Multiply latency/busy, with a request held pending that must be ignored.
      issue(16'h1800, 16'h0100, 16'h0100, 1'b1, 16'h0000, 4'b0011);
      n = 0;
      busy_cnt = 0;
      while (!bus.out_valid && n < 40) begin
         if (bus.busy && !bus.in_ready) busy_cnt++;
         bus.in_valid = (n < 8);
         bus.opcode   = 16'h1000;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      check("mul_latency", 32'(n), 32'd16);
      check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
      check("mul_done_busy", 32'(bus.busy), 32'h0);
      wait_drain();

      issue(16'h1800, 16'h0003, 16'h0005, 1'b1, 16'h000F, 4'b0000);
      issue(16'h1800, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 4'b0010);
      wait_drain();

      // Backpressure: result must hold and no new request may be taken.
      bus.out_ready = 1'b0;
      issue(16'h1000, 16'h0001, 16'h0002, 1'b1, 16'h0003, 4'b0000);
      stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (bus.c !== 16'h0003 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
         @(posedge clk);
         #1;
      end
      check("bp_stable", 32'(stable), 32'h1);
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      bus.out_ready = 1'b1;
      wait_drain();

      // Logic ops and shift boundaries.
      issue(16'h1200, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 4'b0100);
      issue(16'h1300, 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 4'b0000);
      issue(16'h1400, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b0001);
      issue(16'h1500, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, 4'b0100);
      issue(16'h1600, 16'h8000, 16'h0010, 1'b1, 16'h8000, 4'b0100);
      issue(16'h1700, 16'h8000, 16'h000F, 1'b1, 16'h0001, 4'b0000);
      issue(16'h10FF, 16'h0001, 16'h0001, 1'b1, 16'h0002, 4'b0000);

      // Non-ALU selects keep flags; undefined operations give 0 / Z.
      issue(16'h1000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b0001);
      issue(16'h2000, 16'h0005, 16'h0006, 1'b1, 16'h0000, 4'b0001);
      issue(16'h1100, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b0110);
      issue(16'h2000, 16'h0005, 16'h0006, 1'b1, 16'h0000, 4'b0110);
      issue(16'h1A00, 16'h0005, 16'h0006, 1'b1, 16'h0000, 4'b0001);
`ifdef ALU_DIV_EN
      issue(16'h1900, 16'h0064, 16'h0007, 1'b1, 16'h000E, 4'b0000);
      issue(16'h1900, 16'h0007, 16'h0000, 1'b1, 16'hFFFF, 4'b1110);
`else
      issue(16'h1900, 16'h0007, 16'h0000, 1'b1, 16'h0000, 4'b0001);
`endif
      wait_drain();

      // Reset during a multiply abandons it.
      issue(16'h1000, 16'h00AA, 16'h0011, 1'b1, 16'h00BB, 4'b0000);
      wait_drain();
      issue(16'h1800, 16'h0003, 16'h0005, 1'b0, 16'h0000, 4'b0000);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midmul_reset_c", 32'(bus.c), 32'h0);
      check("midmul_reset_flags", 32'(bus.flags), 32'b0001);
      check("midmul_reset_out_valid", 32'(bus.out_valid), 32'h0);
      check("midmul_reset_in_ready", 32'(bus.in_ready), 32'h1);
      check("midmul_reset_busy", 32'(bus.busy), 32'h0);
      repeat (30) @(posedge clk);
      #1;
      issue(16'h1000, 16'h0002, 16'h0002, 1'b1, 16'h0004, 4'b0000);
      wait_drain();

      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
